// File: rtl/switch_pkg.sv
// Shared defaults and sizing helpers for the DIP-switch debounce block.
package switch_pkg;

  localparam int SW_WIDTH        = 16;
  localparam int SW_TICK_DIV     = 24000;
  localparam int SW_STABLE_TICKS = 10;

  // Bits needed to hold the values 0..n_values-1; never less than one bit.
  function automatic int cnt_width(input int n_values);
    return (n_values < 2) ? 1 : $clog2(n_values);
  endfunction

endpackage : switch_pkg

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-FF synchronizer, stability counter, debounced level and
// registered rise/fall pulses. The shared tick comes from the top level.
module switch_debounce_bit
  import switch_pkg::*;
#(
  parameter int   STABLE_TICKS = SW_STABLE_TICKS,
  parameter logic RESET_BIT    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic event_d_o
);

  localparam int            CW   = cnt_width(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          meta_q, sync_q;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    // Agreement with the accepted level clears the window, tick or not.
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == LAST) begin
        stable_d = sync_q;
        cnt_d    = '0;
        rise_d   = sync_q;
        fall_d   = ~sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= RESET_BIT;
      sync_q   <= RESET_BIT;
      stable_q <= RESET_BIT;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // this is what makes meta_q -> sync_q a true two-stage synchronizer.
      meta_q   <= raw_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o  = stable_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign event_d_o = rise_d | fall_d;

endmodule : switch_debounce_bit

// File: rtl/switch_debounce.sv
// DIP-switch conditioner: shared tick prescaler, settle-window valid flag,
// WIDTH per-bit debouncers and the aggregate change pulse.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int               WIDTH        = SW_WIDTH,
  parameter int               TICK_DIV     = SW_TICK_DIV,
  parameter int               STABLE_TICKS = SW_STABLE_TICKS,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed,
  output logic             sw_valid
);

  localparam int            PW    = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
  localparam int            VW    = cnt_width(STABLE_TICKS + 1);
  localparam logic [VW-1:0] VLAST = VW'(STABLE_TICKS - 1);

  logic [PW-1:0]    presc_q, presc_d;
  logic [VW-1:0]    vcnt_q, vcnt_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;
  logic             tick;
  logic [WIDTH-1:0] event_d;

  always_comb begin
    tick      = (presc_q == PLAST);
    presc_d   = tick ? '0 : presc_q + PW'(1);
    vcnt_d    = vcnt_q;
    valid_d   = valid_q;
    changed_d = |event_d;
    // Once valid, the tick counter freezes; only reset clears the flag.
    if (tick && !valid_q) begin
      if (vcnt_q == VLAST) valid_d = 1'b1;
      else                 vcnt_d  = vcnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      vcnt_q    <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      vcnt_q    <= vcnt_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_BIT    (RESET_VAL[i])
    ) u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (tick),
      .raw_i     (switch[i]),
      .stable_o  (sw_stable[i]),
      .rise_o    (sw_rise[i]),
      .fall_o    (sw_fall[i]),
      .event_d_o (event_d[i])
    );
  end

  assign sw_changed = changed_q;
  assign sw_valid   = valid_q;

endmodule : switch_debounce

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Input-side conditioner for the 16 on-board DIP switches.
- Synchronizes each raw switch bit into the system clock domain and debounces it against a millisecond-scale tick.
- Publishes clean levels plus one-cycle rise/fall event pulses.
- Sits between the board switch pins and any logic consuming switch state, such as LED drivers or mode registers.

Parameters:
- WIDTH, 16, number of switch bits.
- TICK_DIV, 24000, clk cycles per debounce tick (1 ms at 24 MHz); legal range ≥ 2.
- STABLE_TICKS, 10, consecutive ticks a changed input must hold before it is accepted; legal range ≥ 1.
- RESET_VAL, 16'h0000, value of sw_stable during and after reset.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- switch  input  WIDTH  raw switch pins, asynchronous to clk.
- sw_stable  output  WIDTH  debounced switch level.
- sw_rise  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 change.
- sw_fall  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 change.
- sw_changed  output  1  one-cycle pulse when any sw_rise or sw_fall bit is set.
- sw_valid  output  1  high once the first full settle window after reset has elapsed.

Behaviour:
- Reset is asynchronous, active-low: clock and reset are fixed as one clock `clk` and reset `rst_n`, asynchronous assert.
- Reset values:
  - sync stages = RESET_VAL.
  - sw_stable = RESET_VAL.
  - sw_rise, sw_fall = 0.
  - sw_changed = 0.
  - sw_valid = 0.
  - prescaler = 0.
  - all per-bit counters = 0.
  - valid counter = 0.
- Synchronizer: 2 flip-flops per bit; sync = second stage. Raw-to-sync latency is 2 cycles.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick is high for exactly the one cycle where prescaler == TICK_DIV-1. The prescaler is free-running and shared by all bits.
- Per-bit counter, width clog2(STABLE_TICKS+1):
  - Any cycle with sync[i] == sw_stable[i]: counter clears to 0, whether or not a tick occurs. Bounce restarts the window.
  - Tick cycle with sync[i] != sw_stable[i] and counter < STABLE_TICKS-1: counter increments.
  - Tick cycle with sync[i] != sw_stable[i] and counter == STABLE_TICKS-1: on the next edge, sw_stable[i] <= sync[i], counter <= 0, and the matching sw_rise[i] or sw_fall[i] is 1 for that single cycle.
- Acceptance time: between STABLE_TICKS-1 and STABLE_TICKS full tick periods after sync changes, depending on prescaler phase, plus 2 sync cycles.
- Pulse outputs:
  - sw_rise, sw_fall and sw_changed are registered and deasserted in every cycle that is not an acceptance cycle.
  - Multiple bits may pulse in the same cycle.
  - sw_changed = OR of all pulses, registered in the same cycle as the pulses.
- sw_valid: a separate counter counts ticks after reset. sw_valid rises on the edge after the STABLE_TICKS-th tick and stays high until the next reset.
- Events during !sw_valid are still reported through sw_rise and sw_fall.
- Boundary cases:
  - Input toggling faster than one tick: never accepted, no pulses.
  - Input returning to the stable value on the acceptance tick itself: the equality clear wins, no change.
  - Reset asserted mid-window: all state returns to reset values immediately, no pulse is emitted.
  - STABLE_TICKS == 1: acceptance on the first tick seen while sync differs.

Decomposition:
- Shared package switch_pkg holds:
  - default constants SW_WIDTH=16, SW_TICK_DIV=24000, SW_STABLE_TICKS=10.
  - a clog2-based counter-width localparam function.
- One natural sub-module, switch_debounce_bit: contains the 2-FF synchronizer, counter, stable flop and rise/fall pulse for a single bit, with inputs tick and RESET_VAL bit.
- The top level holds the prescaler, valid counter, generate loop of WIDTH instances, and the sw_changed OR.

Test Plan (sim parameters TICK_DIV=4, STABLE_TICKS=3, RESET_VAL=0):
- Release rst_n with switch=16'h0000 held -> sw_stable=0, no pulses ever, sw_valid rises on the edge after tick #3, i.e. cycle 12 after reset release.
- Step switch[0] 0->1 and hold -> sw_stable[0]=1 within 2+8..2+12 cycles; sw_rise=16'h0001 and sw_changed=1 for exactly one cycle; sw_fall stays 0.
- Toggle switch[5] every 3 cycles for 40 cycles -> sw_stable[5] unchanged, zero pulses on all outputs.
- Step switch to 16'hA5A5 in one cycle from 0, hold -> all eight bits accepted in the same cycle; sw_rise=16'hA5A5 for one cycle; a single sw_changed pulse.
- Hold switch[3]=1 for 2 ticks, then assert rst_n=0 for 1 cycle -> outputs return to 0 asynchronously, no sw_rise pulse; after release, the bit is re-accepted a full window later.
- From sw_stable=16'hFFFF, step switch to 16'h0000 -> sw_fall=16'hFFFF for one cycle, sw_stable=0, sw_rise=0.
